// File: rtl/frv_pipeline_register.sv
// Elastic stage register: a small FIFO between pipeline stages with registered
// valid/busy handshakes. It supports flush and non-power-of-two depth.
module frv_pipeline_register #(
    parameter  int RLEN  = 8,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            i_valid,
    output logic            i_busy,
    input  logic [RLEN-1:0] i_data,
    output logic            o_valid,
    input  logic            o_busy,
    output logic [RLEN-1:0] o_data,
    output logic [CW-1:0]   o_count
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    logic [RLEN-1:0] mem_q [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            push, pop;

    // Handshakes come only from registered occupancy, so o_busy never reaches i_busy.
    assign i_busy  = (count_q == FULL);
    assign o_valid = (count_q != '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q[AW-1:0]];

    assign push = i_valid & ~i_busy & ~flush;
    assign pop  = o_valid & ~o_busy & ~flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + CW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is zeroed by reset only; flush just rewinds the pointers.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: tb/tb_frv_pipeline_register.sv
// Directed bench: three instances (DEPTH 2, 3, 1) driven by hand-written steps.
module tb_frv_pipeline_register;

    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    int total = 0;
    int bad   = 0;

    // DEPTH=2 instance
    logic       a_flush, a_iv, a_ib, a_ov, a_ob;
    logic [7:0] a_id, a_od;
    logic [1:0] a_cnt;
    // DEPTH=3 instance
    logic       b_flush, b_iv, b_ib, b_ov, b_ob;
    logic [7:0] b_id, b_od;
    logic [1:0] b_cnt;
    // DEPTH=1 instance
    logic       c_flush, c_iv, c_ib, c_ov, c_ob;
    logic [7:0] c_id, c_od;
    logic [0:0] c_cnt;

    frv_pipeline_register #(.RLEN(8), .DEPTH(2)) dut_a (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(a_flush),
        .i_valid(a_iv), .i_busy(a_ib), .i_data(a_id),
        .o_valid(a_ov), .o_busy(a_ob), .o_data(a_od), .o_count(a_cnt));

    frv_pipeline_register #(.RLEN(8), .DEPTH(3)) dut_b (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(b_flush),
        .i_valid(b_iv), .i_busy(b_ib), .i_data(b_id),
        .o_valid(b_ov), .o_busy(b_ob), .o_data(b_od), .o_count(b_cnt));

    frv_pipeline_register #(.RLEN(8), .DEPTH(1)) dut_c (
        .g_clk(g_clk), .g_resetn(g_resetn), .flush(c_flush),
        .i_valid(c_iv), .i_busy(c_ib), .i_data(c_id),
        .o_valid(c_ov), .o_busy(c_ob), .o_data(c_od), .o_count(c_cnt));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns later, inputs change there too.
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic v, input logic b,
                         input logic [7:0] d, input logic [1:0] n);
        check({tag, ".o_valid"}, 32'(a_ov), 32'(v));
        check({tag, ".i_busy"},  32'(a_ib), 32'(b));
        check({tag, ".o_data"},  32'(a_od), 32'(d));
        check({tag, ".o_count"}, 32'(a_cnt), 32'(n));
        $display("step %s: v=%0b busy=%0b data=%02h cnt=%0d", tag, a_ov, a_ib, a_od, a_cnt);
    endtask

    initial begin
        g_resetn = 1'b0;
        a_flush = 0; a_iv = 0; a_id = 0; a_ob = 0;
        b_flush = 0; b_iv = 0; b_id = 0; b_ob = 0;
        c_flush = 0; c_iv = 0; c_id = 0; c_ob = 0;
        #2;
        tick();
        chk_a("reset", 0, 0, 8'h00, 2'd0);
        check("reset_b.o_valid", 32'(b_ov), 32'd0);
        check("reset_c.o_data",  32'(c_od), 32'd0);
        g_resetn = 1'b1;

        // ---- DEPTH=2: fill while blocked, hold, full+pop, drain
        a_ob = 1; a_iv = 1; a_id = 8'h11;
        tick(); chk_a("push11", 1, 0, 8'h11, 2'd1);
        a_id = 8'h22;
        tick(); chk_a("push22_full", 1, 1, 8'h11, 2'd2);
        a_id = 8'h99;
        tick(); chk_a("full_hold", 1, 1, 8'h11, 2'd2);
        a_ob = 0; a_id = 8'h33;
        tick(); chk_a("full_pop_push_rejected", 1, 0, 8'h22, 2'd1);
        a_iv = 0;
        tick(); chk_a("drain22", 0, 0, a_od, 2'd0);

        // ---- flush with concurrent push
        a_ob = 1; a_iv = 1; a_id = 8'hAA;
        tick();
        a_id = 8'hBB;
        tick(); chk_a("fill_aabb", 1, 1, 8'hAA, 2'd2);
        a_flush = 1; a_id = 8'hCC;
        tick(); chk_a("flush", 0, 0, 8'hAA, 2'd0);
        a_flush = 0; a_iv = 0;
        tick(); chk_a("post_flush", 0, 0, 8'hAA, 2'd0);

        // ---- simultaneous push and pop at partial occupancy
        a_iv = 1; a_id = 8'h44;
        tick(); chk_a("push44", 1, 0, 8'h44, 2'd1);
        a_ob = 0; a_id = 8'h55;
        tick(); chk_a("push_pop", 1, 0, 8'h55, 2'd1);
        a_iv = 0;
        tick(); chk_a("drain55", 0, 0, a_od, 2'd0);

        // ---- mid-operation reset
        a_ob = 1; a_iv = 1; a_id = 8'h66;
        tick();
        a_id = 8'h77;
        tick(); chk_a("fill_6677", 1, 1, 8'h66, 2'd2);
        a_iv = 0; g_resetn = 0;
        tick(); chk_a("mid_reset", 0, 0, 8'h00, 2'd0);
        g_resetn = 1;

        // ---- DEPTH=3: ten streamed values, pointers wrap repeatedly
        b_ob = 0; b_iv = 1;
        for (int k = 1; k <= 10; k++) begin
            b_id = 8'(k);
            tick();
            check("stream.o_data",  32'(b_od), 32'(k));
            check("stream.o_count", 32'(b_cnt), 32'd1);
            $display("stream k=%0d data=%02h cnt=%0d", k, b_od, b_cnt);
        end
        b_iv = 0;
        tick();
        check("stream_end.o_valid", 32'(b_ov), 32'd0);

        // ---- DEPTH=3: fill to three from a non-zero pointer, then drain in order
        b_ob = 1; b_iv = 1;
        for (int k = 0; k < 3; k++) begin
            b_id = 8'hA1 + 8'(k);
            tick();
        end
        b_iv = 0;
        check("fill3.i_busy",  32'(b_ib), 32'd1);
        check("fill3.o_count", 32'(b_cnt), 32'd3);
        b_ob = 0;
        for (int k = 0; k < 3; k++) begin
            check("drain3.o_data", 32'(b_od), 32'hA1 + 32'(k));
            $display("drain3 k=%0d data=%02h", k, b_od);
            tick();
        end
        check("drain3.o_count", 32'(b_cnt), 32'd0);

        // ---- DEPTH=1: one entry every two cycles
        c_ob = 0; c_iv = 1;
        for (int v = 1; v <= 4; v++) begin
            c_id = 8'(v);
            tick();
            check("d1.o_valid_on",  32'(c_ov), 32'd1);
            check("d1.o_data",      32'(c_od), 32'(v));
            check("d1.i_busy",      32'(c_ib), 32'd1);
            c_id = 8'hEE;
            tick();
            check("d1.o_valid_off", 32'(c_ov), 32'd0);
            $display("d1 v=%0d ok-cycle pair", v);
        end
        c_iv = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frv_pipeline_register.md
FRV_PIPELINE_REGISTER -- requirements
Module: frv_pipeline_register

Interface
REQ-001 Parameter RLEN, default 8: payload width in bits, legal range 1 to 256.
REQ-002 Parameter DEPTH, default 2: buffer entries, legal range 1 to 8; need not be a power of two.
REQ-003 Parameter CW, derived, not overridable: $clog2(DEPTH+1), the occupancy counter width.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 g_clk  input  1  global clock.
REQ-006 g_resetn  input  1  synchronous reset, active-low.
REQ-007 flush  input  1  discard all buffered entries.
REQ-008 i_valid  input  1  upstream payload valid.
REQ-009 i_busy  output  1  stage cannot accept new input.
REQ-010 i_data  input  RLEN  upstream payload.
REQ-011 o_valid  output  1  head entry valid.
REQ-012 o_busy  input  1  downstream cannot accept.
REQ-013 o_data  output  RLEN  head entry payload.
REQ-014 o_count  output  CW  current occupancy, 0 to DEPTH.

Function
REQ-015 A push SHALL occur on a rising edge where i_valid=1, i_busy=0 and flush=0.
REQ-016 A pop SHALL occur on a rising edge where o_valid=1, o_busy=0 and flush=0.
REQ-017 i_busy SHALL equal (o_count==DEPTH), driven from registered state only, with no combinational path from o_busy.
REQ-018 o_valid SHALL equal (o_count!=0), driven from registered state only.
REQ-019 o_data SHALL be the oldest unpopped entry; ordering is strict FIFO.
REQ-020 Latency: a pushed payload SHALL appear on o_data with o_valid=1 one cycle after its push edge when the buffer was empty.
REQ-021 Simultaneous push and pop with 0<o_count<DEPTH: o_count SHALL be unchanged and ordering preserved.
REQ-022 When full, a push is blocked even if a pop occurs the same cycle; i_busy SHALL deassert the cycle after the pop.
REQ-023 Read and write pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-024 DEPTH=1: sustained throughput SHALL be one entry per two cycles under continuous i_valid with o_busy=0.
REQ-025 Flush SHALL set o_count, read pointer and write pointer to 0 on its edge; any concurrent push and pop are discarded.
REQ-026 After a flush edge, o_valid=0 and i_busy=0 SHALL hold the next cycle.
REQ-027 Flush SHALL NOT clear storage contents.
REQ-028 i_data and i_valid SHALL be ignored while i_busy=1.
REQ-029 o_data SHALL be held stable while o_valid=1 and o_busy=1.
REQ-030 o_data is don't-care when o_valid=0, except after reset, when it SHALL be 0.

Reset
REQ-031 On an edge with g_resetn=0: o_count=0, pointers=0, all storage entries=0.
REQ-032 Resulting outputs after that edge: o_valid=0, i_busy=0, o_data=0.
REQ-033 Reset SHALL take priority over flush, push and pop.
REQ-034 Reset asserted mid-operation SHALL discard all entries with no output on the following cycle.

Structure
REQ-035 No new package SHALL be created; any shared constants SHALL live in frv_common.vh.
REQ-036 No sub-module SHALL be instantiated; storage SHALL be an inline register array.
REQ-037 The block SHALL be usable as the s2->s3 and s3->s4 stage register, with payload fields concatenated by the instantiating module.
REQ-038 Pointer and counter arithmetic SHALL be done at CW width without overflow.

Verification
REQ-039 DEPTH=2, RLEN=8: push 0x11 then 0x22 with o_busy=1 -> i_busy=1 and o_count=2; then o_busy=0 -> pops 0x11 then 0x22, o_count=0.
REQ-040 DEPTH=3: 10 continuous pushes 0x01..0x0A with o_busy=0 -> all values out in order, pointers wrap, no loss and no duplicates.
REQ-041 DEPTH=2: fill with 0xAA and 0xBB, assert flush together with i_valid=1 carrying 0xCC -> next cycle o_valid=0, o_count=0, and 0xCC never appears on o_data.
REQ-042 DEPTH=1: i_valid held at 1 with data 1..4 and o_busy=0 -> one output every two cycles, values 1..4 in order.
REQ-043 Full buffer, o_busy=0 and i_valid=1 on the same edge -> head popped, push rejected, i_busy=0 on the next cycle.
REQ-044 g_resetn=0 for one cycle with o_count=2 -> o_valid=0, o_data=0 and o_count=0 on the following cycle.
